secure_reg_bank: RTL and testbench



---
 rtl/secure_reg_bank.sv | 79 +++++++
 tb/tb_secure_reg_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/secure_reg_bank.sv
// Multi-channel capture register bank with per-channel reset values, write enables
// and sticky locks; a post-reset scrub pass reloads every channel before writes are accepted.
module secure_reg_bank #(
  parameter int unsigned                 NUM_CH    = 3,
  parameter int unsigned                 WIDTH     = 8,
  parameter logic [NUM_CH*WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]       lock_set,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       locked,
  output logic                    ready,
  output logic                    wr_err
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

  typedef enum logic {S_SCRUB, S_READY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [NUM_CH*WIDTH-1:0] r_data;
  logic [NUM_CH-1:0]       r_locked;
  logic                    r_wr_err;
  logic [NUM_CH-1:0]       w_scrub_sel;
  logic                    w_wr_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_SCRUB;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_err    = 1'b0;
    w_scrub_sel = '0;
    if (r_state == S_SCRUB) begin
      if (r_cnt == LAST) w_state_nxt = S_READY;
      // Any write attempt while scrubbing is refused outright.
      w_wr_err = |wr_en;
      for (int unsigned i = 0; i < NUM_CH; i++)
        w_scrub_sel[i] = (r_cnt == CW'(i));
    end else begin
      w_wr_err = |(wr_en & r_locked);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= RESET_VAL;
      r_locked <= '0;
      r_cnt    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_err;
      if (r_state == S_SCRUB) begin
        if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
        for (int unsigned i = 0; i < NUM_CH; i++)
          if (w_scrub_sel[i]) r_data[i*WIDTH +: WIDTH] <= RESET_VAL[i*WIDTH +: WIDTH];
      end else begin
        // Lock check uses the pre-edge lock, so write-then-lock in one cycle succeeds.
        for (int unsigned i = 0; i < NUM_CH; i++)
          if (wr_en[i] && !r_locked[i]) r_data[i*WIDTH +: WIDTH] <= data_in[i*WIDTH +: WIDTH];
        r_locked <= r_locked | lock_set;
      end
    end
  end

  assign data_out = r_data;
  assign locked   = r_locked;
  assign ready    = (r_state == S_READY);
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_secure_reg_bank.sv
// Directed vector bench for secure_reg_bank (3x8 main instance, 1x4 instance for single-cycle scrub).
module tb_secure_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wr_en = '0;
  logic [23:0] data_in = '0;
  logic [2:0]  lock_set = '0;
  logic [23:0] data_out;
  logic [2:0]  locked;
  logic        ready;
  logic        wr_err;

  logic        rst1 = 1'b1;
  logic [0:0]  wr_en1 = '0;
  logic [3:0]  data_in1 = '0;
  logic [0:0]  lock_set1 = '0;
  logic [3:0]  data_out1;
  logic [0:0]  locked1;
  logic        ready1;
  logic        wr_err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  secure_reg_bank #(.NUM_CH(3), .WIDTH(8), .RESET_VAL(24'hC3B2A1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .lock_set(lock_set),
    .data_out(data_out), .locked(locked), .ready(ready), .wr_err(wr_err)
  );

  secure_reg_bank #(.NUM_CH(1), .WIDTH(4), .RESET_VAL(4'h5)) dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr_en1), .data_in(data_in1), .lock_set(lock_set1),
    .data_out(data_out1), .locked(locked1), .ready(ready1), .wr_err(wr_err1)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  wr_en;
    logic [23:0] din;
    logic [2:0]  lset;
    logic [23:0] e_data;
    logic [2:0]  e_lock;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, wr_en, data_in, lock_set, exp data_out, exp locked, exp ready, exp wr_err
    vecs[0]  = '{1'b1, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 24'h556677, 3'b000, 24'h55B277, 3'b000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 24'h000000, 3'b010, 24'h55B277, 3'b010, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 24'h00FF00, 3'b000, 24'h55B277, 3'b010, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'h55B277, 3'b010, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'b001, 24'h00003C, 3'b001, 24'h55B23C, 3'b011, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'b001, 24'h000099, 3'b000, 24'h55B23C, 3'b011, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'h55B23C, 3'b011, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'b111, 24'h112233, 3'b000, 24'h11B23C, 3'b011, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 3'b010, 24'h000000, 3'b000, 24'h11B23C, 3'b011, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'h11B23C, 3'b011, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 3'b111, 24'hFFFFFF, 3'b111, 24'hC3B2A1, 3'b000, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 3'b111, 24'h0A0B0C, 3'b111, 24'h0A0B0C, 3'b111, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 3'b000, 24'h000000, 3'b000, 24'hC3B2A1, 3'b000, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 3'b001, 24'h000077, 3'b000, 24'hC3B277, 3'b000, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst      = vecs[i].rst;
      wr_en    = vecs[i].wr_en;
      data_in  = vecs[i].din;
      lock_set = vecs[i].lset;
      tick();
      chk("data_out", i, 32'(data_out), 32'(vecs[i].e_data));
      chk("locked",   i, 32'(locked),   32'(vecs[i].e_lock));
      chk("ready",    i, 32'(ready),    32'(vecs[i].e_rdy));
      chk("wr_err",   i, 32'(wr_err),   32'(vecs[i].e_err));
    end

    // Bounded wait on ready after a fresh reset, checking outputs stay X-free.
    wr_en = '0; lock_set = '0; data_in = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!ready && cyc < 10) begin
        tick();
        cyc++;
        chk("no_x", cyc, 32'($isunknown({data_out, locked, ready, wr_err})), 32'd0);
      end
      chk("ready_latency", 0, 32'(cyc), 32'd3);
    end

    // Single-channel instance: scrub completes after one cycle.
    rst1 = 1'b1;
    tick();
    chk("c1_data_rst", 0, 32'(data_out1), 32'h5);
    chk("c1_ready_rst", 0, 32'(ready1), 32'd0);
    rst1 = 1'b0;
    wr_en1 = 1'b1; data_in1 = 4'hE;
    tick();
    chk("c1_ready", 1, 32'(ready1), 32'd1);
    chk("c1_scrub_err", 1, 32'(wr_err1), 32'd1);
    chk("c1_scrub_data", 1, 32'(data_out1), 32'h5);
    wr_en1 = 1'b1; lock_set1 = 1'b1; data_in1 = 4'hA;
    tick();
    chk("c1_wl_data", 2, 32'(data_out1), 32'hA);
    chk("c1_wl_lock", 2, 32'(locked1), 32'd1);
    lock_set1 = 1'b0; data_in1 = 4'h3;
    tick();
    chk("c1_rej_data", 3, 32'(data_out1), 32'hA);
    chk("c1_rej_err", 3, 32'(wr_err1), 32'd1);
    wr_en1 = 1'b0;
    tick();
    chk("c1_err_clear", 4, 32'(wr_err1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
